// File: rtl/adder_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module   : adder_arbiter_if
// Purpose  : Requester and response handshake bundle for adder_arbiter.
// Revision : 1.0 - initial release
// =============================================================================
interface adder_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    localparam int IDW = $clog2(R);

    logic [R-1:0]   req_valid;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R-1:0]   req_ready;
    logic           rsp_valid;
    logic [N:0]     rsp_sum;
    logic [IDW-1:0] rsp_id;
    logic           rsp_ready;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : adder_arbiter
// Purpose  : Round-robin arbiter sharing one N-bit adder among R requesters,
//            with a single registered, backpressured response port.
// Build    : define ADDER_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
// Revision : 1.0 - initial release
// =============================================================================
module adder_arbiter #(
    parameter int N = 8,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    localparam int             IDW = $clog2(R);
    localparam logic [IDW:0]   c_R = (IDW+1)'(R);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] w_ptr;
    logic [IDW-1:0] w_win_idx;
    logic           w_any;
    logic           w_accept;
    logic           w_xfer;
    logic [R-1:0]   w_grant;
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic [N:0]     w_sum;
    logic [N:0]     r_sum;
    logic [IDW-1:0] r_id;

    // Search ptr, ptr+1, ... modulo R; first valid requester wins.
    always_comb begin
        logic [IDW:0] v_cand;
        w_any     = 1'b0;
        w_win_idx = '0;
        v_cand    = '0;
        for (int k = 0; k < R; k++) begin
            v_cand = {1'b0, w_ptr} + k[IDW:0];
            if (v_cand >= c_R) begin
                v_cand = v_cand - c_R;
            end
            if (!w_any && bus.req_valid[v_cand[IDW-1:0]]) begin
                w_any     = 1'b1;
                w_win_idx = v_cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < R; i++) begin
            if (w_win_idx == i[IDW-1:0]) begin
                w_a = bus.req_a[i*N +: N];
                w_b = bus.req_b[i*N +: N];
            end
        end
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant is gated by rst_n so req_ready is 0 throughout reset.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_grant     = '0;
        case (r_state)
            S_EMPTY: w_accept = 1'b1;
            S_FULL:  w_accept = bus.rsp_ready;
            default: w_accept = 1'b0;
        endcase
        if (rst_n && w_accept && w_any) begin
            w_grant[w_win_idx] = 1'b1;
        end
        w_xfer = |w_grant;
        if (w_xfer) begin
            w_state_nxt = S_FULL;
        end else if ((r_state == S_FULL) && bus.rsp_ready) begin
            w_state_nxt = S_EMPTY;
        end
    end

`ifdef ADDER_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    localparam logic [IDW-1:0] c_LAST = IDW'(R - 1);
    logic [IDW-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_win_idx == c_LAST) ? '0 : w_win_idx + 1'b1;
        end
    end

    assign w_ptr = r_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_id  <= '0;
        end else if (w_xfer) begin
            r_sum <= w_sum;
            r_id  <= w_win_idx;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = (r_state == S_FULL);
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_id    = r_id;
endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_adder_arbiter
// Purpose  : Self-checking bench for adder_arbiter: reference model plus
//            directed scenarios with hand-computed values.
// Revision : 1.0 - initial release
// =============================================================================
module tb_adder_arbiter;
    localparam int N = 8;
    localparam int R = 4;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    adder_arbiter_if #(.N(N), .R(R)) bus ();

    adder_arbiter #(.N(N), .R(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        bus.req_valid[i]     = v;
        bus.req_a[i*N +: N]  = a;
        bus.req_b[i*N +: N]  = b;
    endtask

    // Reference model: response register contents, pointer and the grant
    // implied by the current inputs; checked each negedge.
    int           m_valid;
    int           m_sum;
    int           m_id;
    int           m_ptr;
    logic [R-1:0] m_rdy;

    initial begin
        int g;
        m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0;
        forever begin
            @(negedge clk);
            m_rdy = '0;
            g     = -1;
            if (!rst_n) begin
                m_valid = 0; m_sum = 0; m_id = 0; m_ptr = 0;
            end else if (m_valid == 0 || bus.rsp_ready) begin
                for (int k = 0; k < R; k++) begin
                    if (g < 0 && bus.req_valid[(m_ptr + k) % R]) g = (m_ptr + k) % R;
                end
                if (g >= 0) m_rdy[g] = 1'b1;
            end
            chk("m_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
            chk("m_rsp_sum",   32'(bus.rsp_sum),   32'(m_sum));
            chk("m_rsp_id",    32'(bus.rsp_id),    32'(m_id));
            chk("m_req_ready", 32'(bus.req_ready), 32'(m_rdy));
            if (g >= 0) begin
                m_sum   = int'(bus.req_a[g*N +: N]) + int'(bus.req_b[g*N +: N]);
                m_id    = g;
                m_valid = 1;
`ifndef ADDER_ARB_FIXED_PRIO_EN
                m_ptr   = (g + 1) % R;
`endif
            end else if (rst_n && m_valid == 1 && bus.rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < R; i++) set_req(i, 1'b1, 8'h11, 8'h22);
        repeat (2) tick();
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);

        // Reset release: first grant in the first cycle
        tick();
        rst_n = 1'b1;
        bus.req_valid = '0;
        set_req(2, 1'b1, 8'h01, 8'h02);
        #1;
        chk("first_grant", 32'(bus.req_ready), 32'h4);

        tick();
        set_req(2, 1'b0, 8'h01, 8'h02);
        set_req(0, 1'b1, 8'hFF, 8'h01);
        #1;
        chk("first_sum", 32'(bus.rsp_sum), 32'h003);
        chk("first_id",  32'(bus.rsp_id),  32'd2);
        chk("carry_grant", 32'(bus.req_ready), 32'h1);

        tick();
        set_req(0, 1'b0, 8'hFF, 8'h01);
        set_req(2, 1'b1, 8'h40, 8'h41);
        #1;
        chk("carry_sum", 32'(bus.rsp_sum), 32'h100);
        chk("carry_id",  32'(bus.rsp_id),  32'd0);
        chk("carry_next_grant", 32'(bus.req_ready), 32'h4);

`ifdef ADDER_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 4; k++) begin
            tick();
            for (int i = 0; i < R; i++) set_req(i, 1'b1, 8'(128 + i), 8'h80);
            #1;
            chk("fixed_grant", 32'(bus.req_ready), 32'h1);
            if (k > 0) begin
                chk("fixed_id",  32'(bus.rsp_id),  32'd0);
                chk("fixed_sum", 32'(bus.rsp_sum), 32'h100);
            end
        end
`else
        // Skip and wrap: ptr is 3, only requesters 1 and 3 valid
        tick();
        set_req(2, 1'b0, 8'h40, 8'h41);
        set_req(1, 1'b1, 8'h05, 8'h06);
        set_req(3, 1'b1, 8'h07, 8'h08);
        #1;
        chk("wrap_grant3", 32'(bus.req_ready), 32'h8);
        chk("wrap_sum_prev", 32'(bus.rsp_sum), 32'h081);

        tick();
        set_req(3, 1'b0, 8'h07, 8'h08);
        #1;
        chk("wrap_grant1", 32'(bus.req_ready), 32'h2);
        chk("wrap_sum3", 32'(bus.rsp_sum), 32'h00F);
        chk("wrap_id3",  32'(bus.rsp_id),  32'd3);

        tick();
        set_req(1, 1'b0, 8'h05, 8'h06);
        set_req(3, 1'b1, 8'h09, 8'h0A);
        #1;
        chk("align_grant3", 32'(bus.req_ready), 32'h8);
        chk("wrap_id1", 32'(bus.rsp_id), 32'd1);

        // Fairness: all valid, ptr is 0
        for (int k = 0; k < 5; k++) begin
            tick();
            for (int i = 0; i < R; i++) set_req(i, 1'b1, 8'(128 + i), 8'h80);
            #1;
            chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
            if (k == 0) begin
                chk("rr_sum_first", 32'(bus.rsp_sum), 32'h013);
            end else begin
                chk("rr_id",  32'(bus.rsp_id),  32'((k - 1) % 4));
                chk("rr_sum", 32'(bus.rsp_sum), 32'(256 + (k - 1) % 4));
            end
        end

        // Backpressure for three cycles
        for (int j = 0; j < 3; j++) begin
            tick();
            bus.rsp_ready = 1'b0;
            #1;
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_sum", 32'(bus.rsp_sum), 32'h100);
            chk("bp_id",  32'(bus.rsp_id),  32'd0);
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
        end
        tick();
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(bus.req_ready), 32'h2);
        tick();
        #1;
        chk("bp_after_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_after_sum", 32'(bus.rsp_sum), 32'h101);
        chk("bp_after_id",  32'(bus.rsp_id),  32'd1);
`endif

        // Asynchronous reset while FULL with a stalled response
        tick();
        bus.rsp_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'h0);
        chk("mid_rst_sum",   32'(bus.rsp_sum),   32'h0);
        chk("mid_rst_id",    32'(bus.rsp_id),    32'h0);
        chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);

        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = '0;
        set_req(2, 1'b1, 8'h01, 8'h02);
        #1;
        chk("post_rst_grant", 32'(bus.req_ready), 32'h4);
        tick();
        set_req(2, 1'b0, 8'h01, 8'h02);
        #1;
        chk("post_rst_sum", 32'(bus.rsp_sum), 32'h003);
        chk("post_rst_id",  32'(bus.rsp_id),  32'd2);
        tick();
        #1;
        chk("drain_valid", 32'(bus.rsp_valid), 32'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
